sprite_reg_bank: RTL and testbench

SPRITE_REG_BANK -- requirements
Module: sprite_reg_bank

---
 rtl/sprite_reg_pkg.sv | 29 ++
 rtl/frame_sync.sv | 33 +++
 rtl/sprite_reg_bank.sv | 134 +++++++++++++
 tb/tb_sprite_reg_bank.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_reg_pkg.sv
// Shared constants for the sprite register bank: sizes, register map, CTRL bits and reset defaults.
// Latency and backpressure are not applicable; this package holds constants only.
package sprite_reg_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_W    = 10;

  localparam logic [8:0] ADDR_CTRL    = 9'd16;
  localparam logic [8:0] ADDR_DIRTY   = 9'd17;
  localparam logic [8:0] ADDR_FRAME   = 9'd18;
  localparam logic [8:0] ADDR_IRQ_ACK = 9'd19;

  localparam int CTRL_IMM_BIT = 0;
  localparam int CTRL_FRZ_BIT = 1;

  localparam int unsigned RST_DFLT [16] = '{
    100, 100, 200, 150, 300, 550, 500, 100,
    100, 460,   0,  25,  41,   0,   0,   0
  };

  // Entries beyond the table reset to zero so larger banks stay well defined.
  function automatic int unsigned reg_default(input int idx);
    int unsigned v;
    v = 0;
    if (idx >= 0 && idx < 16) v = RST_DFLT[idx[3:0]];
    return v;
  endfunction

endpackage

// File: rtl/frame_sync.sv
// Vsync falling-edge detector and frame counter; the edge is found against a registered copy of vga_vs.
// commit_o pulses for one cycle while the new low level meets the old high copy; no backpressure.
module frame_sync (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vga_vs_i,
  output logic        commit_o,
  output logic [15:0] frame_count_o
);

  logic        vs_q, vs_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    vs_d     = vga_vs_i;
    commit_o = vs_q & ~vga_vs_i;
    cnt_d    = cnt_q;
    if (commit_o) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q  <= 1'b1;
      cnt_q <= 16'd0;
    end else begin
      vs_q  <= vs_d;
      cnt_q <= cnt_d;
    end
  end

  assign frame_count_o = cnt_q;

endmodule

// File: rtl/sprite_reg_bank.sv
// Double-buffered sprite registers on Avalon-MM; shadow commits to active on vsync fall; reads take one cycle.
// The commit interrupt on address 19 is built only when SPRITE_REG_IRQ_EN is defined; no backpressure.
module sprite_reg_bank
  import sprite_reg_pkg::*;
#(
  parameter int NUM_REGS = sprite_reg_pkg::NUM_REGS,
  parameter int REG_W    = sprite_reg_pkg::REG_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      chipselect,
  input  logic                      write,
  input  logic                      read,
  input  logic [8:0]                address,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  input  logic                      vga_vs,
  output logic [NUM_REGS*REG_W-1:0] active_regs,
  output logic [15:0]               frame_count,
  output logic                      irq
);

  logic [NUM_REGS-1:0][REG_W-1:0] shadow_q, shadow_d;
  logic [NUM_REGS-1:0][REG_W-1:0] active_q, active_d;
  logic [NUM_REGS-1:0]            dirty_q, dirty_d;
  logic [1:0]                     ctrl_q, ctrl_d;
  logic [31:0]                    readdata_q, readdata_d, rdata_mux;
  logic                           commit_stb, do_commit, wr_en, rd_en;
  logic [REG_W-1:0]               wdata;
  logic                           unused_wdata;

  frame_sync u_frame_sync (
    .clk           (clk),
    .reset_n       (reset_n),
    .vga_vs_i      (vga_vs),
    .commit_o      (commit_stb),
    .frame_count_o (frame_count)
  );

  assign wr_en        = chipselect & write;
  assign rd_en        = chipselect & read;
  assign wdata        = writedata[REG_W-1:0];
  assign do_commit    = commit_stb & ~ctrl_q[CTRL_FRZ_BIT];
  assign unused_wdata = ^writedata;

  // Commit is applied first so a same-cycle write re-dirties its entry.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    dirty_d  = dirty_q;
    ctrl_d   = ctrl_q;
    if (do_commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (dirty_q[i]) begin
          active_d[i] = shadow_q[i];
          dirty_d[i]  = 1'b0;
        end
      end
    end
    if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (address == 9'(i)) begin
          shadow_d[i] = wdata;
          if (ctrl_q[CTRL_IMM_BIT]) begin
            active_d[i] = wdata;
            dirty_d[i]  = 1'b0;
          end else begin
            dirty_d[i]  = 1'b1;
          end
        end
      end
      if (address == ADDR_CTRL) ctrl_d = writedata[1:0];
    end
  end

  always_comb begin
    rdata_mux = 32'd0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (address == 9'(i)) rdata_mux = 32'(shadow_q[i]);
    end
    case (address)
      ADDR_CTRL:    rdata_mux = 32'(ctrl_q);
      ADDR_DIRTY:   rdata_mux = 32'(dirty_q);
      ADDR_FRAME:   rdata_mux = 32'(frame_count);
`ifdef SPRITE_REG_IRQ_EN
      ADDR_IRQ_ACK: rdata_mux = 32'(irq);
`endif
      default:      ;
    endcase
    readdata_d = rd_en ? rdata_mux : readdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= REG_W'(reg_default(i));
        active_q[i] <= REG_W'(reg_default(i));
      end
      dirty_q    <= '0;
      ctrl_q     <= 2'b00;
      readdata_q <= 32'd0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      dirty_q    <= dirty_d;
      ctrl_q     <= ctrl_d;
      readdata_q <= readdata_d;
    end
  end

`ifdef SPRITE_REG_IRQ_EN
  logic irq_q, irq_d;

  // A commit outranks a same-cycle acknowledge.
  always_comb begin
    irq_d = irq_q;
    if (wr_en && address == ADDR_IRQ_ACK && writedata[0]) irq_d = 1'b0;
    if (do_commit) irq_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign readdata    = readdata_q;
  assign active_regs = active_q;

endmodule

// File: tb/tb_sprite_reg_bank.sv
// Directed table-driven bench for sprite_reg_bank plus hand sequences for commit alignment, irq and reset.
module tb_sprite_reg_bank;

  localparam int NR = 16;
  localparam int RW = 10;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [8:0]     address = '0;
  logic [31:0]    writedata = '0;
  logic [31:0]    readdata;
  logic           vga_vs = 1'b1;
  logic [NR*RW-1:0] active_regs;
  logic [15:0]    frame_count;
  logic           irq;

  sprite_reg_bank dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .chipselect  (chipselect),
    .write       (write),
    .read        (read),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata),
    .vga_vs      (vga_vs),
    .active_regs (active_regs),
    .frame_count (frame_count),
    .irq         (irq)
  );

  always #10 clk = ~clk;

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_ACT, OP_VS} op_e;
  typedef struct {
    op_e         op;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int unsigned dflt [NR] = '{100, 100, 200, 150, 300, 550, 500, 100,
                             100, 460, 0, 25, 41, 0, 0, 0};

  task automatic add(input op_e op, input int a, input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.op = op; v.addr = 9'(a); v.data = d; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] act_entry(input int idx);
    return 32'(active_regs[idx*RW +: RW]);
  endfunction

  task automatic av_write(input int a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = 9'(a); writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic av_read(input int a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = 9'(a);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic vsync();
    @(negedge clk);
    vga_vs = 1'b0;
    @(negedge clk);
    vga_vs = 1'b1;
  endtask

  // Commit strobe and a register write in the same clock cycle.
  task automatic vsync_with_write(input int a, input logic [31:0] d);
    @(negedge clk);
    vga_vs = 1'b0; chipselect = 1'b1; write = 1'b1; address = 9'(a); writedata = d;
    @(negedge clk);
    vga_vs = 1'b1; chipselect = 1'b0; write = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;

    // Reset state
    add(OP_RD, 0, 0, 100);      add(OP_RD, 9, 0, 460);
    add(OP_RD, 12, 0, 41);      add(OP_RD, 13, 0, 0);
    add(OP_RD, 16, 0, 0);       add(OP_RD, 17, 0, 0);
    add(OP_RD, 18, 0, 0);
    // Shadow write then vsync commit
    add(OP_WR, 0, 32'h1F0, 0);  add(OP_ACT, 0, 0, 100);
    add(OP_RD, 17, 0, 1);       add(OP_RD, 0, 0, 32'h1F0);
    add(OP_VS, 0, 0, 0);        add(OP_ACT, 0, 0, 32'h1F0);
    add(OP_RD, 17, 0, 0);       add(OP_RD, 18, 0, 1);
    // Immediate mode
    add(OP_WR, 16, 1, 0);       add(OP_RD, 16, 0, 1);
    add(OP_WR, 9, 77, 0);       add(OP_ACT, 9, 0, 77);
    add(OP_RD, 17, 0, 0);       add(OP_RD, 9, 0, 77);
    add(OP_WR, 16, 0, 0);
    // Upper writedata bits are dropped
    add(OP_WR, 2, 32'hFFFF_FC05, 0); add(OP_RD, 2, 0, 5);
    add(OP_RD, 17, 0, 4);       add(OP_ACT, 2, 0, 200);
    add(OP_VS, 0, 0, 0);        add(OP_ACT, 2, 0, 5);
    add(OP_RD, 18, 0, 2);
    // Unmapped addresses
    add(OP_WR, 25, 32'h3FF, 0); add(OP_RD, 25, 0, 0);
    add(OP_RD, 20, 0, 0);       add(OP_RD, 511, 0, 0);
    add(OP_RD, 17, 0, 0);
    // Freeze across three vsyncs, then release
    add(OP_WR, 16, 2, 0);       add(OP_WR, 3, 32'h2AA, 0);
    add(OP_VS, 0, 0, 0);        add(OP_VS, 0, 0, 0);
    add(OP_VS, 0, 0, 0);        add(OP_ACT, 3, 0, 150);
    add(OP_RD, 18, 0, 5);       add(OP_RD, 17, 0, 8);
    add(OP_RD, 16, 0, 2);       add(OP_WR, 16, 0, 0);
    add(OP_ACT, 3, 0, 150);     add(OP_VS, 0, 0, 0);
    add(OP_ACT, 3, 0, 32'h2AA); add(OP_RD, 17, 0, 0);
    add(OP_RD, 18, 0, 6);

    repeat (3) @(negedge clk);
    check("rst_readdata", readdata, 0);
    check("rst_frame", 32'(frame_count), 0);
    check("rst_irq", 32'(irq), 0);
    for (int i = 0; i < NR; i++) check($sformatf("rst_active%0d", i), act_entry(i), 32'(dflt[i]));
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].op)
        OP_WR:  av_write(int'(tbl[i].addr), tbl[i].data);
        OP_RD:  begin
          av_read(int'(tbl[i].addr), rd);
          check($sformatf("vec%0d_rd%0d", i, tbl[i].addr), rd, tbl[i].exp);
        end
        OP_ACT: check($sformatf("vec%0d_act%0d", i, tbl[i].addr), act_entry(int'(tbl[i].addr)), tbl[i].exp);
        default: vsync();
      endcase
    end

    // Write landing in the commit cycle stays dirty until the following vsync
    av_write(4, 32'h0AB);
    vsync_with_write(5, 32'h155);
    check("align_act4", act_entry(4), 32'h0AB);
    check("align_act5_held", act_entry(5), 550);
    av_read(17, rd);
    check("align_dirty", rd, 32'h20);
    av_read(5, rd);
    check("align_shadow5", rd, 32'h155);
    vsync();
    check("align_act5_next", act_entry(5), 32'h155);
    av_read(17, rd);
    check("align_dirty_clr", rd, 0);
    check("align_frame", 32'(frame_count), 8);

    // readdata holds between reads
    av_read(0, rd);
    check("hold_first", rd, 32'h1F0);
    repeat (3) @(negedge clk);
    check("hold_later", readdata, 32'h1F0);

`ifdef SPRITE_REG_IRQ_EN
    check("irq_after_commit", 32'(irq), 1);
    av_read(19, rd);
    check("irq_read", rd, 1);
    av_write(19, 1);
    check("irq_ack", 32'(irq), 0);
    vsync();
    check("irq_set", 32'(irq), 1);
    vsync_with_write(19, 1);
    check("irq_ack_vs_commit", 32'(irq), 1);
    av_write(19, 1);
    check("irq_ack_iso", 32'(irq), 0);
`else
    check("irq_tied", 32'(irq), 0);
    av_read(19, rd);
    check("irq_addr_unmapped", rd, 0);
`endif

    // Reset in the middle of a frame with a commit pending
    av_write(7, 32'h3FF);
    av_write(16, 32'h2);
    @(negedge clk);
    vga_vs = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vga_vs = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NR; i++) check($sformatf("rst2_active%0d", i), act_entry(i), 32'(dflt[i]));
    check("rst2_frame", 32'(frame_count), 0);
    check("rst2_readdata", readdata, 0);
    check("rst2_irq", 32'(irq), 0);
    av_read(7, rd);
    check("rst2_shadow7", rd, 100);
    av_read(17, rd);
    check("rst2_dirty", rd, 0);
    av_read(16, rd);
    check("rst2_ctrl", rd, 0);
    av_read(20, rd);
    check("rst2_unmapped", rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
